fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle control block for the RV32I core.
- Owns the program counter and issues fetch requests to instruction memory over a valid/ready handshake.
- Presents each fetched instruction to the single-instruction datapath as a one-cycle execute strobe.
- Applies branch/jump redirects from the datapath and halts on ECALL/EBREAK, an illegal encoding or a misaligned target.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- run  in  1  enable sequencing; when low, the sequencer parks in IDLE after the current instruction.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  XLEN  byte address of the fetch; equals pc.
- imem_rsp_valid  in  1  fetch data valid.
- imem_rsp_data  in  32  fetched instruction word.
- instr  out  32  latched instruction presented to the datapath.
- instr_valid  out  1  execute/commit strobe, exactly one cycle per instruction.
- redirect_valid  in  1  datapath requests a non-sequential next PC; sampled only in EXEC.
- redirect_pc  in  XLEN  target of the redirect.
- pc  out  XLEN  address of the current instruction.
- retired_count  out  XLEN  number of instructions retired.
- halted  out  1  sticky halt flag.
- fault  out  1  sticky flag: halt caused by an illegal encoding or a misaligned redirect.

Behaviour:
- Reset (any state, any cycle):
  - state=IDLE, pc=RESET_PC, instr=0, retired_count=0.
  - instr_valid, imem_req_valid, halted and fault all 0.
  - Reset has priority over every other input.
- IDLE: outputs idle. run=1 -> REQ. Any imem_rsp_valid seen in IDLE is ignored.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Address and valid are held stable until imem_req_ready=1; then -> WAIT.
  - run is not re-checked here.
- WAIT:
  - Memory never responds in the acceptance cycle.
  - On imem_rsp_valid=1: instr <= imem_rsp_data, -> EXEC.
  - Only one fetch is outstanding at a time.
- EXEC: instr_valid=1 for this one cycle. Priority order:
  1. instr[1:0]!=2'b11 -> HALT; fault=1; no retire; pc unchanged.
  2. instr==32'h0000_0073 (ECALL) or 32'h0010_0073 (EBREAK) -> HALT; retire; pc unchanged.
  3. redirect_valid=1 with redirect_pc[1:0]!=0 -> HALT; fault=1; no retire.
  4. Otherwise: retire; pc <= redirect_valid ? redirect_pc : pc+4. Then -> REQ if run=1, else -> IDLE.
- HALT: halted=1; no requests issued regardless of run. Exit only via reset.
- Retire means retired_count+1.
- Arithmetic: pc+4 and retired_count both wrap modulo 2^XLEN. No overflow flag.
- Best-case throughput: 3 cycles per instruction (REQ with ready=1, WAIT with response in the next cycle, EXEC).
- Reset during WAIT: the late response is dropped and pc returns to RESET_PC.

Test Plan:
- Single ADDI:
  - Stimulus: reset; mem[0]=32'h00C0_0293 (addi x5,x0,12); run=1; ready=1; 1-cycle response.
  - Required: imem_req_addr=0 in the first REQ cycle; instr_valid pulses once with instr=32'h00C0_0293 on the 3rd cycle after run; then pc=4, retired_count=1, x5=12 in the datapath.
- Five sequential instructions (addi 120, addi 200, addi x5,x5,2000, andi 0xFFF, ori 0xA) with imem_req_ready held low for 2 cycles on the 3rd fetch:
  - Request addresses 0,4,8,C,10 in order; addr held stable during the stall.
  - Exactly 5 instr_valid pulses; retired_count=5.
  - x5 sequence 120, 200, 2200, 0, 10.
- Redirect:
  - redirect_valid=1, redirect_pc=0x40 during EXEC at pc=8 -> next imem_req_addr=0x40, retired_count increments.
  - redirect_pc=0x42 -> halted=1, fault=1, retired_count unchanged, no further requests.
- ECALL 32'h0000_0073 at 0x10 with run=1:
  - One instr_valid pulse, retired_count increments, halted=1, fault=0, pc stays 0x10.
  - imem_req_valid stays 0 for 10 further cycles.
- Reset mid-fetch: assert reset in WAIT, then imem_rsp_valid=1 the following cycle -> state IDLE, pc=0, instr_valid=0, instr=0, retired_count=0.
- Wrap and park:
  - RESET_PC=32'hFFFF_FFFC, one non-branch instruction -> next imem_req_addr=32'h0000_0000.
  - Drop run during WAIT -> that instruction completes, then no new request while run=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer for the RV32I core: owns the PC, fetches one word at a time over a
// valid/ready port, strobes each instruction to the datapath and halts on system/illegal/misaligned events.
module fetch_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] retired_count,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, EXEC, HALT} state_t;

  localparam logic [31:0] ECALL_W  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  state_t state;

  function automatic logic [XLEN-1:0] wrap_inc(input logic [XLEN-1:0] v, input logic [XLEN-1:0] step);
    return v + step;
  endfunction

  function automatic logic is_system(input logic [31:0] w);
    return (w == ECALL_W) || (w == EBREAK_W);
  endfunction

  assign imem_req_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      instr          <= '0;
      retired_count  <= '0;
      instr_valid    <= 1'b0;
      imem_req_valid <= 1'b0;
      halted         <= 1'b0;
      fault          <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (run) begin
            state          <= REQ;
            imem_req_valid <= 1'b1;
          end
        end
        REQ: begin
          if (imem_req_ready) begin
            state          <= WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            instr       <= imem_rsp_data;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          // Checks are ordered: encoding, system call, then redirect alignment.
          if (instr[1:0] != 2'b11) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else if (is_system(instr)) begin
            state         <= HALT;
            halted        <= 1'b1;
            retired_count <= wrap_inc(retired_count, XLEN'(1));
          end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state  <= HALT;
            halted <= 1'b1;
            fault  <= 1'b1;
          end else begin
            retired_count <= wrap_inc(retired_count, XLEN'(1));
            pc            <= redirect_valid ? redirect_pc : wrap_inc(pc, XLEN'(4));
            if (run) begin
              state          <= REQ;
              imem_req_valid <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory responder, small x5 datapath model and a program-level
// reference interpreter; directed scenarios plus randomized programs with random ready/latency.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] ADDI12 = 32'h00C0_0293;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, imem_req_valid, imem_req_ready, imem_rsp_valid, instr_valid;
  logic        redirect_valid, halted, fault;
  logic [31:0] imem_req_addr, imem_rsp_data, instr, redirect_pc, pc, retired_count;
  logic        resetw, runw, req_validw, readyw, rspw_valid, instr_validw, haltedw, faultw;
  logic [31:0] req_addrw, rspw_data, instrw, pcw, retiredw;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_valid(instr_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .retired_count(retired_count), .halted(halted), .fault(fault)
  );

  fetch_sequencer #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dutw (
    .clk(clk), .reset(resetw), .run(runw),
    .imem_req_valid(req_validw), .imem_req_ready(readyw), .imem_req_addr(req_addrw),
    .imem_rsp_valid(rspw_valid), .imem_rsp_data(rspw_data),
    .instr(instrw), .instr_valid(instr_validw),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .pc(pcw), .retired_count(retiredw), .halted(haltedw), .fault(faultw)
  );

  logic [31:0] mem   [logic [31:0]];
  logic [31:0] redir [logic [31:0]];
  logic [31:0] acc_q[$], pls_pc_q[$], pls_ins_q[$], x5_q[$];
  logic [31:0] x5;
  int n_chk = 0, n_pass = 0, stab_err = 0;
  bit auto_mem = 0, rand_ready = 0, rand_lat = 0;
  logic [31:0] stall_addr;
  int stall_left = 0;
  bit pend = 0;
  logic [31:0] pend_addr;
  int lat = 0;
  bit prev_v = 0, prev_acc = 0;
  logic [31:0] prev_a;
  logic [31:0] m_pc_q[$], m_ins_q[$], m_pc;
  int m_ret;
  bit m_fault;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Instruction memory: one outstanding fetch, response no earlier than the cycle after acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        imem_rsp_valid = 1'b0;
        if (pend) begin
          if (lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_rd(pend_addr);
            pend = 0;
          end else lat--;
        end
        if (imem_req_valid && stall_left > 0 && imem_req_addr == stall_addr) begin
          imem_req_ready = 1'b0;
          stall_left--;
        end else imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!reset && prev_v && !prev_acc && (!imem_req_valid || imem_req_addr !== prev_a)) stab_err++;
        prev_v   = imem_req_valid && !reset;
        prev_a   = imem_req_addr;
        prev_acc = imem_req_valid && imem_req_ready;
        if (!reset && imem_req_valid && imem_req_ready) begin
          pend      = 1;
          pend_addr = imem_req_addr;
          lat       = rand_lat ? $urandom_range(0, 3) : 0;
          acc_q.push_back(imem_req_addr);
        end
      end
    end
  end

  // Datapath stand-in: logs each strobe, supplies redirects and tracks x5 for addi/andi/ori.
  initial begin : monitor
    logic [31:0] src, imm;
    forever begin
      @(negedge clk);
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if (instr_valid === 1'b1) begin
        pls_pc_q.push_back(pc);
        pls_ins_q.push_back(instr);
        if (redir.exists(pc)) begin
          redirect_valid = 1'b1;
          redirect_pc    = redir[pc];
        end
        if (instr[6:0] == 7'h13 && instr[11:7] == 5'd5) begin
          src = (instr[19:15] == 5'd5) ? x5 : 32'h0;
          imm = {{20{instr[31]}}, instr[31:20]};
          case (instr[14:12])
            3'b000:  x5 = src + imm;
            3'b111:  x5 = src & imm;
            3'b110:  x5 = src | imm;
            default: x5 = x5;
          endcase
          x5_q.push_back(x5);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // Program-level interpreter: walks the program in memory and records the expected strobes.
  task automatic model(input logic [31:0] start);
    logic [31:0] p, w;
    bit done;
    m_pc_q.delete(); m_ins_q.delete();
    m_ret = 0; m_fault = 0; done = 0; p = start;
    for (int s = 0; s < 200 && !done; s++) begin
      w = mem_rd(p);
      m_pc_q.push_back(p);
      m_ins_q.push_back(w);
      if (w[1:0] != 2'b11) begin m_fault = 1; done = 1; end
      else if (w == ECALL || w == EBREAK) begin m_ret++; done = 1; end
      else if (redir.exists(p) && redir[p][1:0] != 2'b00) begin m_fault = 1; done = 1; end
      else begin m_ret++; p = redir.exists(p) ? redir[p] : p + 32'd4; end
    end
    m_pc = p;
  endtask

  task automatic do_reset();
    @(negedge clk);
    auto_mem = 0; rand_ready = 0; rand_lat = 0; stall_left = 0;
    pend = 0; prev_v = 0; prev_acc = 0;
    reset = 1; resetw = 1; run = 0; runw = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    readyw = 0; rspw_valid = 0; rspw_data = 0;
    mem.delete(); redir.delete(); acc_q.delete(); pls_pc_q.delete(); pls_ins_q.delete(); x5_q.delete();
    x5 = 0; stab_err = 0;
    repeat (2) @(negedge clk);
    reset = 0; resetw = 0;
  endtask

  task automatic wait_halt(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (halted === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else n_pass++;
    n_chk++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
    n_chk++; if (retired_count !== 32'h0) $display("FAIL reset_retired: got %0d want 0", retired_count); else n_pass++;
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b want 0", instr_valid); else n_pass++;
    n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_chk++; if ({halted, fault} !== 2'b00) $display("FAIL reset_halt_fault: got %b want 00", {halted, fault}); else n_pass++;
    n_chk++; if (pcw !== 32'hFFFF_FFFC) $display("FAIL reset_pc_param: got %h want fffffffc", pcw); else n_pass++;
  endtask

  task automatic test_single_addi();
    do_reset();
    mem[32'h0] = ADDI12;
    auto_mem = 1; run = 1;
    @(negedge clk);
    n_chk++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL addi_req: got %b/%h want 1/0", imem_req_valid, imem_req_addr); else n_pass++;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL addi_early_strobe: got %b want 0", instr_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if ({instr_valid, instr} !== {1'b1, ADDI12}) $display("FAIL addi_strobe: got %b/%h want 1/%h", instr_valid, instr, ADDI12); else n_pass++;
    run = 0;
    @(negedge clk);
    n_chk++; if ({pc, retired_count} !== {32'h4, 32'h1}) $display("FAIL addi_commit: got pc %h ret %0d want 4/1", pc, retired_count); else n_pass++;
    repeat (5) @(negedge clk);
    n_chk++; if (pls_pc_q.size() !== 1) $display("FAIL addi_pulses: got %0d want 1", pls_pc_q.size()); else n_pass++;
    n_chk++; if (x5 !== 32'd12) $display("FAIL addi_x5: got %0d want 12", x5); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] prog [5];
    logic [31:0] exp_x5 [5];
    prog   = '{32'h0780_0293, 32'h0C80_0293, 32'h7D02_8293, 32'hFFF0_7293, 32'h00A2_E293};
    exp_x5 = '{32'd120, 32'd200, 32'd2200, 32'd0, 32'd10};
    do_reset();
    for (int i = 0; i < 5; i++) mem[32'(4 * i)] = prog[i];
    stall_addr = 32'h8; stall_left = 2;
    auto_mem = 1; run = 1;
    for (int i = 0; i < 200 && acc_q.size() < 5; i++) @(negedge clk);
    run = 0;
    repeat (12) @(negedge clk);
    n_chk++; if (acc_q.size() !== 5) $display("FAIL seq_req_count: got %0d want 5", acc_q.size()); else n_pass++;
    for (int i = 0; i < 5 && i < acc_q.size(); i++) begin
      n_chk++; if (acc_q[i] !== 32'(4 * i)) $display("FAIL seq_req_addr%0d: got %h want %h", i, acc_q[i], 32'(4 * i)); else n_pass++;
    end
    n_chk++; if (stab_err !== 0) $display("FAIL seq_stall_stable: got %0d violations want 0", stab_err); else n_pass++;
    n_chk++; if (pls_pc_q.size() !== 5) $display("FAIL seq_pulses: got %0d want 5", pls_pc_q.size()); else n_pass++;
    n_chk++; if (retired_count !== 32'd5) $display("FAIL seq_retired: got %0d want 5", retired_count); else n_pass++;
    for (int i = 0; i < 5 && i < x5_q.size(); i++) begin
      n_chk++; if (x5_q[i] !== exp_x5[i]) $display("FAIL seq_x5_%0d: got %0d want %0d", i, x5_q[i], exp_x5[i]); else n_pass++;
    end
    n_chk++; if ({imem_req_valid, halted} !== 2'b00) $display("FAIL seq_parked: got %b want 00", {imem_req_valid, halted}); else n_pass++;
  endtask

  task automatic test_redirect();
    bit ok;
    int a0, vcnt;
    do_reset();
    mem[32'h0] = ADDI12; mem[32'h4] = ADDI12; mem[32'h8] = ADDI12; mem[32'h40] = ADDI12;
    redir[32'h8] = 32'h40; redir[32'h40] = 32'h42;
    model(32'h0);
    auto_mem = 1; run = 1;
    wait_halt(300, ok);
    n_chk++; if (!ok) $display("FAIL redir_halt_timeout: got running want halted"); else n_pass++;
    n_chk++; if (acc_q.size() !== 4 || acc_q[3] !== 32'h40) $display("FAIL redir_target_req: got %0d reqs want 4 ending at 40", acc_q.size()); else n_pass++;
    n_chk++; if (pls_pc_q.size() !== m_pc_q.size()) $display("FAIL redir_pulses: got %0d want %0d", pls_pc_q.size(), m_pc_q.size()); else n_pass++;
    n_chk++; if (retired_count !== 32'(m_ret)) $display("FAIL redir_retired: got %0d want %0d", retired_count, m_ret); else n_pass++;
    n_chk++; if ({halted, fault} !== 2'b11) $display("FAIL redir_fault: got %b want 11", {halted, fault}); else n_pass++;
    a0 = acc_q.size(); vcnt = 0;
    repeat (10) begin @(negedge clk); if (imem_req_valid) vcnt++; end
    n_chk++; if (vcnt != 0 || acc_q.size() != a0) $display("FAIL redir_no_req: got %0d valid cycles want 0", vcnt); else n_pass++;
  endtask

  task automatic test_ecall();
    bit ok;
    int vcnt;
    do_reset();
    for (int i = 0; i < 4; i++) mem[32'(4 * i)] = ADDI12;
    mem[32'h10] = ECALL;
    model(32'h0);
    auto_mem = 1; run = 1;
    wait_halt(300, ok);
    n_chk++; if (!ok) $display("FAIL ecall_halt_timeout: got running want halted"); else n_pass++;
    n_chk++; if (retired_count !== 32'(m_ret)) $display("FAIL ecall_retired: got %0d want %0d", retired_count, m_ret); else n_pass++;
    n_chk++; if ({halted, fault} !== 2'b10) $display("FAIL ecall_flags: got %b want 10", {halted, fault}); else n_pass++;
    n_chk++; if (pc !== m_pc) $display("FAIL ecall_pc: got %h want %h", pc, m_pc); else n_pass++;
    n_chk++; if (pls_pc_q.size() !== 5) $display("FAIL ecall_pulses: got %0d want 5", pls_pc_q.size()); else n_pass++;
    vcnt = 0;
    repeat (10) begin @(negedge clk); if (imem_req_valid) vcnt++; end
    n_chk++; if (vcnt != 0) $display("FAIL ecall_no_req: got %0d valid cycles want 0", vcnt); else n_pass++;
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    run = 1; imem_req_ready = 1;
    @(negedge clk);
    @(negedge clk);
    n_chk++; if (imem_req_valid !== 1'b0) $display("FAIL midrst_wait: got req_valid %b want 0", imem_req_valid); else n_pass++;
    reset = 1; imem_req_ready = 0;
    @(negedge clk);
    reset = 0; run = 0; imem_rsp_valid = 1; imem_rsp_data = ADDI12;
    @(negedge clk);
    imem_rsp_valid = 0;
    n_chk++; if ({instr_valid, instr} !== {1'b0, 32'h0}) $display("FAIL midrst_instr: got %b/%h want 0/0", instr_valid, instr); else n_pass++;
    n_chk++; if ({pc, retired_count} !== 64'h0) $display("FAIL midrst_pc_ret: got %h/%0d want 0/0", pc, retired_count); else n_pass++;
    @(negedge clk);
    n_chk++; if ({imem_req_valid, instr_valid} !== 2'b00) $display("FAIL midrst_idle: got %b want 00", {imem_req_valid, instr_valid}); else n_pass++;
  endtask

  task automatic test_park();
    do_reset();
    mem[32'h0] = ADDI12; mem[32'h4] = ADDI12;
    auto_mem = 1; run = 1;
    for (int i = 0; i < 50 && acc_q.size() < 1; i++) @(negedge clk);
    @(negedge clk);
    run = 0;
    repeat (12) @(negedge clk);
    n_chk++; if (pls_pc_q.size() !== 1) $display("FAIL park_pulses: got %0d want 1", pls_pc_q.size()); else n_pass++;
    n_chk++; if ({pc, retired_count} !== {32'h4, 32'h1}) $display("FAIL park_commit: got %h/%0d want 4/1", pc, retired_count); else n_pass++;
    n_chk++; if (acc_q.size() !== 1 || imem_req_valid !== 1'b0) $display("FAIL park_no_req: got %0d reqs valid %b want 1/0", acc_q.size(), imem_req_valid); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    runw = 1; readyw = 1;
    @(negedge clk);
    n_chk++; if ({req_validw, req_addrw} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_first_req: got %b/%h want 1/fffffffc", req_validw, req_addrw); else n_pass++;
    @(negedge clk);
    rspw_valid = 1; rspw_data = ADDI12;
    @(negedge clk);
    rspw_valid = 0;
    n_chk++; if (instr_validw !== 1'b1) $display("FAIL wrap_strobe: got %b want 1", instr_validw); else n_pass++;
    @(negedge clk);
    readyw = 0;
    n_chk++; if ({req_validw, req_addrw, retiredw} !== {1'b1, 32'h0, 32'h1}) $display("FAIL wrap_next_req: got %b/%h/%0d want 1/0/1", req_validw, req_addrw, retiredw); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int len, n;
    logic [31:0] w;
    for (int it = 0; it < 8; it++) begin
      do_reset();
      len = $urandom_range(3, 10);
      for (int i = 0; i < len; i++) begin
        w = $urandom();
        w[1:0] = 2'b11;
        if (w == ECALL || w == EBREAK) w = ADDI12;
        mem[32'(4 * i)] = w;
        if ($urandom_range(0, 3) == 0) begin
          w = 32'(4 * $urandom_range(i + 1, len));
          if ($urandom_range(0, 5) == 0) w[1:0] = 2'($urandom_range(1, 3));
          redir[32'(4 * i)] = w;
        end
      end
      case ($urandom_range(0, 2))
        0: w = ECALL;
        1: w = EBREAK;
        default: begin w = $urandom(); w[1:0] = 2'($urandom_range(0, 2)); end
      endcase
      mem[32'(4 * len)] = w;
      model(32'h0);
      rand_ready = 1; rand_lat = 1; auto_mem = 1; run = 1;
      wait_halt(2000, ok);
      repeat (3) @(negedge clk);
      n_chk++; if (!ok) $display("FAIL rand%0d_halt_timeout: got running want halted", it); else n_pass++;
      n = m_pc_q.size();
      n_chk++; if (pls_pc_q.size() !== n || acc_q.size() !== n) $display("FAIL rand%0d_counts: got %0d pulses %0d reqs want %0d", it, pls_pc_q.size(), acc_q.size(), n); else n_pass++;
      for (int i = 0; i < n && i < pls_pc_q.size() && i < acc_q.size(); i++) begin
        n_chk++;
        if (pls_pc_q[i] !== m_pc_q[i] || pls_ins_q[i] !== m_ins_q[i] || acc_q[i] !== m_pc_q[i])
          $display("FAIL rand%0d_step%0d: got pc %h instr %h req %h want %h/%h", it, i, pls_pc_q[i], pls_ins_q[i], acc_q[i], m_pc_q[i], m_ins_q[i]);
        else n_pass++;
      end
      n_chk++; if (retired_count !== 32'(m_ret)) $display("FAIL rand%0d_retired: got %0d want %0d", it, retired_count, m_ret); else n_pass++;
      n_chk++; if ({halted, fault, pc} !== {1'b1, m_fault, m_pc}) $display("FAIL rand%0d_final: got %b%b/%h want 1%b/%h", it, halted, fault, pc, m_fault, m_pc); else n_pass++;
      n_chk++; if (stab_err !== 0) $display("FAIL rand%0d_req_stable: got %0d violations want 0", it, stab_err); else n_pass++;
    end
  endtask

  initial begin
    reset = 1; resetw = 1; run = 0; runw = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    readyw = 0; rspw_valid = 0; rspw_data = 0;
    test_reset();
    test_single_addi();
    test_sequential();
    test_redirect();
    test_ecall();
    test_reset_mid_fetch();
    test_park();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
